// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, alu_op/opcode/funct7 constants, FSM encoding and decode helpers.
// Pure declarations: no latency, no flow control.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;
  localparam logic [3:0] ALU_MUL  = 4'hA;
  localparam logic [3:0] ALU_MULH = 4'hB;
  localparam logic [3:0] ALU_DIV  = 4'hC;
  localparam logic [3:0] ALU_DIVU = 4'hD;
  localparam logic [3:0] ALU_REM  = 4'hE;
  localparam logic [3:0] ALU_REMU = 4'hF;

  localparam logic [1:0] AOP_MEM    = 2'b00;
  localparam logic [1:0] AOP_BRANCH = 2'b01;
  localparam logic [1:0] AOP_RTYPE  = 2'b10;
  localparam logic [1:0] AOP_ITYPE  = 2'b11;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] r;
    case (f3)
      3'b000:  r = ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // MULHSU and MULHU share the MULH code; the ALU resolves signedness itself.
  function automatic logic [3:0] mext_op(input logic [2:0] f3);
    logic [3:0] r;
    case (f3)
      3'b000:  r = ALU_MUL;
      3'b001,
      3'b010,
      3'b011:  r = ALU_MULH;
      3'b100:  r = ALU_DIV;
      3'b101:  r = ALU_DIVU;
      3'b110:  r = ALU_REM;
      default: r = ALU_REMU;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {opcode,funct3,funct7,alu_op} -> {code, illegal, multicycle}.
// Zero latency, no flow control; illegal encodings report ADD.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int EN_MEXT = 1
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic [1:0] alu_op_i,
  output logic [3:0] code_o,
  output logic       illegal_o,
  output logic       multicycle_o
);

  always_comb begin
    code_o       = ALU_ADD;
    illegal_o    = 1'b0;
    multicycle_o = 1'b0;
    case (alu_op_i)
      AOP_MEM: code_o = ALU_ADD;
      AOP_BRANCH: begin
        case (funct3_i[2:1])
          2'b00:   code_o = ALU_SUB;
          2'b10:   code_o = ALU_SLT;
          2'b11:   code_o = ALU_SLTU;
          default: illegal_o = 1'b1;
        endcase
      end
      AOP_RTYPE: begin
        if (opcode_i != OPC_R_TYPE) begin
          illegal_o = 1'b1;
        end else begin
          case (funct7_i)
            F7_BASE: code_o = base_op(funct3_i);
            F7_ALT: begin
              if (funct3_i == 3'b000)      code_o = ALU_SUB;
              else if (funct3_i == 3'b101) code_o = ALU_SRA;
              else                         illegal_o = 1'b1;
            end
            F7_MEXT: begin
              if (EN_MEXT != 0) begin
                code_o       = mext_op(funct3_i);
                multicycle_o = funct3_i[2];
              end else begin
                illegal_o = 1'b1;
              end
            end
            default: illegal_o = 1'b1;
          endcase
        end
      end
      default: begin
        // I-type: funct7 carries shift type only, so it is ignored elsewhere.
        if (funct3_i == 3'b001 && funct7_i != F7_BASE) begin
          illegal_o = 1'b1;
        end else if (funct3_i == 3'b101) begin
          if (funct7_i == F7_BASE)     code_o = ALU_SRL;
          else if (funct7_i == F7_ALT) code_o = ALU_SRA;
          else                         illegal_o = 1'b1;
        end else begin
          code_o = base_op(funct3_i);
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_unit.sv
// Registered ALU control decoder: latency 1 for single-cycle ops, DIV_CYCLES of busy for divides.
// valid/ready on both sides; outputs hold while out_ready is low and in_ready drops.
module alu_ctrl_unit
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int EN_MEXT    = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [1:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              busy
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             illegal_q, illegal_d;

  logic [3:0] dec_code;
  logic       dec_illegal;
  logic       dec_multi;

  alu_ctrl_decode #(.EN_MEXT(EN_MEXT)) u_decode (
    .opcode_i     (opcode),
    .funct3_i     (funct3),
    .funct7_i     (funct7),
    .alu_op_i     (alu_op),
    .code_o       (dec_code),
    .illegal_o    (dec_illegal),
    .multicycle_o (dec_multi)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      code_q    <= ALU_ADD;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      code_d    = ALU_ADD;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_VALID: begin
          // In VALID a new request is only taken when the current result leaves.
          if (state_q == ST_IDLE || out_ready) begin
            if (in_valid) begin
              code_d    = dec_code;
              illegal_d = dec_illegal;
              if (dec_multi) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_LOAD;
              end else begin
                state_d = ST_VALID;
              end
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_d = ST_VALID;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready = rst;
      ST_VALID: begin
        out_valid = 1'b1;
        in_ready  = rst & out_ready;
      end
      ST_WAIT:  busy = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  assign alu_ctrl = CTRL_W'(code_q);
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Bench for alu_ctrl_unit: directed scenarios plus a randomized handshake run against a table-driven model.
module tb_alu_ctrl_unit;

  localparam int DIVC = 32;
  localparam int BASE_TBL [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  localparam int MEXT_TBL [8] = '{10, 11, 11, 11, 12, 13, 14, 15};

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [1:0] alu_op;
  logic       in_ready, out_valid, illegal, busy;
  logic [3:0] alu_ctrl;
  logic       nm_in_ready, nm_out_valid, nm_illegal, nm_busy;
  logic [3:0] nm_alu_ctrl;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_ctrl_unit #(.CTRL_W(4), .EN_MEXT(1), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .busy(busy)
  );

  alu_ctrl_unit #(.CTRL_W(4), .EN_MEXT(0), .DIV_CYCLES(4)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .alu_op(alu_op),
    .out_valid(nm_out_valid), .out_ready(out_ready), .alu_ctrl(nm_alu_ctrl),
    .illegal(nm_illegal), .busy(nm_busy)
  );

  // Model result packed as {illegal, multicycle, code}.
  function automatic logic [5:0] ref_dec(input logic [1:0] a, input logic [6:0] o,
                                         input logic [2:0] f3, input logic [6:0] f7, input bit en_m);
    int code = 0;
    bit ill = 0;
    bit mc = 0;
    if (a == 2'd1) begin
      if (f3 == 3'd2 || f3 == 3'd3) ill = 1;
      else code = (f3 < 3'd2) ? 1 : ((f3 < 3'd6) ? 3 : 4);
    end else if (a == 2'd2) begin
      if (o != 7'h33) ill = 1;
      else if (f7 == 7'h00) code = BASE_TBL[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) code = 1;
      else if (f7 == 7'h20 && f3 == 3'd5) code = 7;
      else if (f7 == 7'h01 && en_m) begin
        code = MEXT_TBL[f3];
        mc = (f3 >= 3'd4);
      end else ill = 1;
    end else if (a == 2'd3) begin
      if (f3 == 3'd1 && f7 != 7'h00) ill = 1;
      else if (f3 == 3'd5 && f7 == 7'h20) code = 7;
      else if (f3 == 3'd5 && f7 != 7'h00) ill = 1;
      else code = BASE_TBL[f3];
    end
    if (ill) code = 0;
    return {ill, mc, 4'(code)};
  endfunction

  task automatic drive(input logic [1:0] a, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    alu_op = a;
    opcode = o;
    funct3 = f3;
    funct7 = f7;
  endtask

  // Issues one request with out_ready=1 and reports what came back and how long it took.
  task automatic do_req(input logic [1:0] a, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                        output logic [3:0] code, output logic ill, output int lat,
                        output int busy_cyc, output bit ir_seen);
    int k = 0;
    busy_cyc = 0;
    ir_seen  = 0;
    @(negedge clk);
    drive(a, o, f3, f7);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cyc++;
      if (in_ready) ir_seen = 1;
      @(negedge clk);
      #1;
      lat++;
    end
    code = alu_ctrl;
    ill  = illegal;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    drive(2'b00, 7'h03, 3'd2, 7'h00);
    repeat (2) @(negedge clk);
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nvec++; if (alu_ctrl !== 4'h0) begin nerr++; $display("FAIL reset_alu_ctrl: got %h want 0", alu_ctrl); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    nvec++; if ({busy, illegal} !== 2'b00) begin nerr++; $display("FAIL reset_busy_illegal: got %b want 00", {busy, illegal}); end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    nvec++; if ({in_ready, out_valid} !== 2'b10) begin nerr++; $display("FAIL release_in_ready: got %b want 10", {in_ready, out_valid}); end
  endtask

  typedef struct {
    logic [1:0] a; logic [6:0] o; logic [2:0] f3; logic [6:0] f7; logic [3:0] code; logic ill;
  } vec_t;

  task automatic run_vecs(input vec_t v [], input string tag);
    logic [3:0] code; logic ill; int lat, bc; bit irs;
    foreach (v[i]) begin
      do_req(v[i].a, v[i].o, v[i].f3, v[i].f7, code, ill, lat, bc, irs);
      nvec++; if ({code, ill} !== {v[i].code, v[i].ill})
        begin nerr++; $display("FAIL %s[%0d]: got code=%h ill=%b want code=%h ill=%b", tag, i, code, ill, v[i].code, v[i].ill); end
      nvec++; if (lat != 1) begin nerr++; $display("FAIL %s_latency[%0d]: got %0d want 1", tag, i, lat); end
    end
  endtask

  task automatic test_rtype();
    vec_t v [] = new[4];
    v[0] = '{2'b10, 7'h33, 3'b000, 7'h20, 4'h1, 1'b0};
    v[1] = '{2'b10, 7'h33, 3'b101, 7'h20, 4'h7, 1'b0};
    v[2] = '{2'b10, 7'h33, 3'b000, 7'h01, 4'hA, 1'b0};
    v[3] = '{2'b10, 7'h33, 3'b000, 7'h03, 4'h0, 1'b1};
    run_vecs(v, "rtype");
  endtask

  task automatic test_branch_itype();
    vec_t v [] = new[3];
    v[0] = '{2'b01, 7'h63, 3'b110, 7'h00, 4'h4, 1'b0};
    v[1] = '{2'b11, 7'h13, 3'b101, 7'h20, 4'h7, 1'b0};
    v[2] = '{2'b11, 7'h13, 3'b001, 7'h01, 4'h0, 1'b1};
    run_vecs(v, "br_itype");
  endtask

  task automatic test_divide();
    logic [3:0] code; logic ill; int lat, bc; bit irs;
    do_req(2'b10, 7'h33, 3'b100, 7'h01, code, ill, lat, bc, irs);
    nvec++; if ({code, ill} !== 5'b1100_0) begin nerr++; $display("FAIL div_result: got code=%h ill=%b want C/0", code, ill); end
    nvec++; if (bc != DIVC) begin nerr++; $display("FAIL div_busy_cycles: got %0d want %0d", bc, DIVC); end
    nvec++; if (lat != DIVC + 1) begin nerr++; $display("FAIL div_latency: got %0d want %0d", lat, DIVC + 1); end
    nvec++; if (irs) begin nerr++; $display("FAIL div_in_ready: got in_ready=1 while busy want 0"); end
  endtask

  task automatic test_no_mext();
    @(negedge clk); flush = 1'b1; in_valid = 1'b0;
    @(negedge clk); flush = 1'b0;
    drive(2'b10, 7'h33, 3'b100, 7'h01);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    #1;
    nvec++; if ({nm_out_valid, nm_illegal, nm_alu_ctrl, nm_busy} !== {1'b1, 1'b1, 4'h0, 1'b0})
      begin nerr++; $display("FAIL nomext_div: got v=%b ill=%b code=%h busy=%b want 1/1/0/0", nm_out_valid, nm_illegal, nm_alu_ctrl, nm_busy); end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive(2'b00, 7'h03, 3'd2, 7'h00);
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    drive(2'b10, 7'h33, 3'b111, 7'h00);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      nvec++; if ({out_valid, alu_ctrl, in_ready} !== {1'b1, 4'h0, 1'b0})
        begin nerr++; $display("FAIL bp_hold[%0d]: got v=%b code=%h rdy=%b want 1/0/0", i, out_valid, alu_ctrl, in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    nvec++; if ({out_valid, alu_ctrl, in_ready} !== {1'b1, 4'h0, 1'b1})
      begin nerr++; $display("FAIL bp_release_first: got v=%b code=%h rdy=%b want 1/0/1", out_valid, alu_ctrl, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    nvec++; if ({out_valid, alu_ctrl} !== {1'b1, 4'h9})
      begin nerr++; $display("FAIL bp_release_second: got v=%b code=%h want 1/9", out_valid, alu_ctrl); end
  endtask

  task automatic test_flush();
    logic [3:0] code; logic ill; int lat, bc; bit irs;
    @(negedge clk);
    drive(2'b10, 7'h33, 3'b100, 7'h01);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (21) @(negedge clk);
    flush = 1'b1;
    #1;
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    nvec++; if ({busy, out_valid, in_ready} !== 3'b001)
      begin nerr++; $display("FAIL flush_clear: got busy/v/rdy=%b want 001", {busy, out_valid, in_ready}); end
    do_req(2'b10, 7'h33, 3'b000, 7'h20, code, ill, lat, bc, irs);
    nvec++; if ({code, ill, lat} !== {4'h1, 1'b0, 32'sd1})
      begin nerr++; $display("FAIL flush_then_sub: got code=%h ill=%b lat=%0d want 1/0/1", code, ill, lat); end
    @(negedge clk);
    drive(2'b00, 7'h03, 3'd2, 7'h00);
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_drop: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive(2'b10, 7'h33, 3'b110, 7'h01);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_wait_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    #1;
    nvec++; if ({busy, out_valid, alu_ctrl, illegal} !== 7'b0)
      begin nerr++; $display("FAIL rst_wait_clear: got busy=%b v=%b code=%h ill=%b want all 0", busy, out_valid, alu_ctrl, illegal); end
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] q[$];
    logic [5:0] r, e;
    logic [1:0] a; logic [6:0] o, f7; logic [2:0] f3;
    logic prev_hold = 1'b0;
    logic [4:0] prev_out = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      a  = 2'($urandom_range(0, 3));
      o  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h33;
      f3 = 3'($urandom);
      case ($urandom_range(0, 4))
        0: f7 = 7'h20;
        1: f7 = 7'h01;
        2: f7 = 7'($urandom);
        default: f7 = 7'h00;
      endcase
      r = ref_dec(a, o, f3, f7, 1'b1);
      if (r[4] && $urandom_range(0, 7) != 0) f7 = 7'h00;
      r = ref_dec(a, o, f3, f7, 1'b1);
      drive(a, o, f3, f7);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_hold) begin
        nvec++; if ({out_valid, alu_ctrl, illegal} !== {1'b1, prev_out})
          begin nerr++; $display("FAIL rnd_hold@%0d: got v=%b code=%h ill=%b want held %h", cyc, out_valid, alu_ctrl, illegal, prev_out); end
      end
      if (out_valid && busy) begin nvec++; nerr++; $display("FAIL rnd_valid_busy@%0d: got both 1 want exclusive", cyc); end
      if (out_valid && out_ready) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++; $display("FAIL rnd_unexpected@%0d: got code=%h with nothing outstanding", cyc, alu_ctrl);
        end else begin
          e = q.pop_front();
          if ({alu_ctrl, illegal} !== {e[3:0], e[5]})
            begin nerr++; $display("FAIL rnd_result@%0d: got code=%h ill=%b want code=%h ill=%b", cyc, alu_ctrl, illegal, e[3:0], e[5]); end
        end
      end
      if (in_valid && in_ready) q.push_back(r);
      prev_hold = out_valid && !out_ready;
      prev_out  = {alu_ctrl, illegal};
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        nvec++; if ({alu_ctrl, illegal} !== {e[3:0], e[5]})
          begin nerr++; $display("FAIL rnd_drain: got code=%h ill=%b want code=%h ill=%b", alu_ctrl, illegal, e[3:0], e[5]); end
      end
      @(negedge clk);
    end
    nvec++; if (q.size() != 0) begin nerr++; $display("FAIL rnd_timeout: got %0d outstanding want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch_itype();
    test_divide();
    test_no_mext();
    test_backpressure();
    test_flush();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
